// File: rtl/alu_load_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_load_seq_pkg
// Shared definitions for the operand/opcode loader: FSM state encoding and
// the six-bit ALU opcode values. Imported by the loader top and its benches.
// ---------------------------------------------------------------------------
package alu_load_seq_pkg;

  // Load-sequence states; encoding is visible on o_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOT_A = 2'd1,
    ST_GOT_B = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] OPC_ADD = 6'b100000;
  localparam logic [5:0] OPC_SUB = 6'b100010;
  localparam logic [5:0] OPC_AND = 6'b100100;
  localparam logic [5:0] OPC_OR  = 6'b100101;
  localparam logic [5:0] OPC_XOR = 6'b100110;
  localparam logic [5:0] OPC_NOR = 6'b100111;
  localparam logic [5:0] OPC_SRL = 6'b000010;
  localparam logic [5:0] OPC_SRA = 6'b000011;

endpackage

// File: rtl/alu_load_seq_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: two-flop synchroniser, debounce counter and
// rising-edge pulse generator.
//   clock    in  system clock
//   reset_n  in  asynchronous active-low reset (debounced level -> 0)
//   i_btn    in  raw, bouncy button level
//   o_pulse  out one-cycle pulse on each debounced 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // Synchronise, count consecutive disagreeing samples, toggle level and emit pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_pulse <= 1'b0;
      if (r_sync1 != r_level) begin
        // The current sample is the DEBOUNCE_CYC-th disagreeing one in a row.
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync1;
          r_cnt   <= '0;
          r_pulse <= r_sync1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_load_seq.sv
// ---------------------------------------------------------------------------
// alu_load_seq
// Loads operand A, operand B and an opcode from switches on debounced button
// presses in the fixed order A -> B -> OP, executes once and holds the
// registered result with flags.
//   clock, reset_n           clock / asynchronous active-low reset
//   i_sw                     switch bus (A/B low DATA_W bits, opcode low OP_W bits)
//   i_btn_a/_b/_op/_clr      raw buttons: load A, load B, load OP+execute, clear
//   o_result                 registered ALU result
//   o_carry/o_overflow       carry (ADD) or borrow (SUB) / signed overflow
//   o_zero/o_err/o_valid     result zero / unsupported opcode / result valid
//   o_state                  FSM state (IDLE=0, GOT_A=1, GOT_B=2, DONE=3)
// ---------------------------------------------------------------------------
module alu_load_seq
  import alu_load_seq_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SW_W         = 16,
  parameter int OP_W         = 6,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [SW_W-1:0]   i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  input  logic              i_btn_clr,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_overflow,
  output logic              o_zero,
  output logic              o_err,
  output logic              o_valid,
  output logic [1:0]        o_state
);

  localparam logic [DATA_W:0] SHIFT_LIM = (DATA_W + 1)'(DATA_W);

  logic w_p_a, w_p_b, w_p_op, w_p_clr;
  logic w_unused_sw;

  state_t            r_state, w_state_nxt;
  logic              w_ld_a, w_ld_b, w_exec, w_clear;
  logic [DATA_W-1:0] r_a, r_b;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_result;
  logic              r_carry, r_overflow, r_zero, r_err, r_valid;

  logic [DATA_W:0]   w_sum, w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_carry, w_ovf, w_err;
  logic              w_big_shift;

  // Upper switch bits are not used by this datapath width.
  assign w_unused_sw = ^i_sw;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_a (
    .clock(clock), .reset_n(reset_n), .i_btn(i_btn_a), .o_pulse(w_p_a));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_b (
    .clock(clock), .reset_n(reset_n), .i_btn(i_btn_b), .o_pulse(w_p_b));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_op (
    .clock(clock), .reset_n(reset_n), .i_btn(i_btn_op), .o_pulse(w_p_op));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clock(clock), .reset_n(reset_n), .i_btn(i_btn_clr), .o_pulse(w_p_clr));

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and load strobes; only the highest-priority pulse is considered.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_exec      = 1'b0;
    w_clear     = 1'b0;
    if (w_p_clr) begin
      w_state_nxt = ST_IDLE;
      w_clear     = 1'b1;
    end else if (w_p_a) begin
      // A may be (re)loaded from any state except GOT_B.
      if (r_state != ST_GOT_B) begin
        w_state_nxt = ST_GOT_A;
        w_ld_a      = 1'b1;
      end else begin
        w_state_nxt = r_state;
      end
    end else if (w_p_b) begin
      if (r_state == ST_GOT_A) begin
        w_state_nxt = ST_GOT_B;
        w_ld_b      = 1'b1;
      end else begin
        w_state_nxt = r_state;
      end
    end else if (w_p_op) begin
      if (r_state == ST_GOT_B) begin
        w_state_nxt = ST_DONE;
        w_exec      = 1'b1;
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
  assign w_big_shift = ({1'b0, r_b} >= SHIFT_LIM);

  // Combinational ALU on the opcode being loaded this cycle (switches),
  // so the result registers on the same edge that samples the op pulse.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (i_sw[OP_W-1:0])
      OP_W'(OPC_ADD): begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
        w_ovf   = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_W'(OPC_SUB): begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];  // borrow: A < B unsigned
        w_ovf   = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_W'(OPC_AND): w_res = r_a & r_b;
      OP_W'(OPC_OR):  w_res = r_a | r_b;
      OP_W'(OPC_XOR): w_res = r_a ^ r_b;
      OP_W'(OPC_NOR): w_res = ~(r_a | r_b);
      OP_W'(OPC_SRL): begin
        if (w_big_shift) begin
          w_res = '0;
        end else begin
          w_res = r_a >> r_b;
        end
      end
      OP_W'(OPC_SRA): begin
        if (w_big_shift) begin
          w_res = {DATA_W{r_a[DATA_W-1]}};
        end else begin
          w_res = $unsigned($signed(r_a) >>> r_b);
        end
      end
      default: begin
        w_res = '0;
        w_err = 1'b1;
      end
    endcase
  end

  // Operand/opcode registers and registered result, flags and valid bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      if (w_ld_a) begin
        r_a <= i_sw[DATA_W-1:0];
      end else begin
        r_a <= r_a;
      end
      if (w_ld_b) begin
        r_b <= i_sw[DATA_W-1:0];
      end else begin
        r_b <= r_b;
      end
      if (w_exec) begin
        r_op       <= i_sw[OP_W-1:0];
        r_result   <= w_res;
        r_carry    <= w_carry;
        r_overflow <= w_ovf;
        r_zero     <= (w_res == '0);
        r_err      <= w_err;
        r_valid    <= 1'b1;
      end else if (w_ld_a || w_clear) begin
        r_valid    <= 1'b0;
      end else begin
        r_valid    <= r_valid;
      end
    end
  end

  assign o_result   = r_result;
  assign o_carry    = r_carry;
  assign o_overflow = r_overflow;
  assign o_zero     = r_zero;
  assign o_err      = r_err;
  assign o_valid    = r_valid;
  assign o_state    = r_state;

endmodule
